// File: rtl/micro_sequencer_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : micro_sequencer_pkg
//  Description : Shared types for the micro-1 micro-sequencer: next-control
//                codes, condition sources, sequencer states and the
//                condition evaluation helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package micro_sequencer_pkg;

   localparam int c_UADDR_WIDTH = 10;

   typedef logic [c_UADDR_WIDTH-1:0] micro_address_t;

   typedef enum logic [2:0] {
      NC_NEXT     = 3'd0,
      NC_JUMP     = 3'd1,
      NC_CJUMP    = 3'd2,
      NC_CALL     = 3'd3,
      NC_RET      = 3'd4,
      NC_DISPATCH = 3'd5,
      NC_WAIT     = 3'd6,
      NC_HALT     = 3'd7
   } next_control_t;

   typedef enum logic [2:0] {
      CS_ONE          = 3'd0,
      CS_ALU_COUT     = 3'd1,
      CS_SHIFTER_COUT = 3'd2,
      CS_LBUS_MSB     = 3'd3,
      CS_RBUS_MSB     = 3'd4,
      CS_SBUS_MSB     = 3'd5,
      CS_ABUS_ZERO    = 3'd6,
      CS_INBUS_VALID  = 3'd7
   } condition_source_t;

   typedef enum logic [1:0] {
      ST_BOOT   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2,
      ST_FAULT  = 2'd3
   } sequencer_state_t;

   // sel[3] inverts, sel[2:0] picks one bit of the status vector, whose
   // bit positions follow the condition_source_t encoding.
   function automatic logic eval_condition(input logic [3:0] sel, input logic [7:0] src);
      condition_source_t w_src;
      w_src = condition_source_t'(sel[2:0]);
      return src[w_src] ^ sel[3];
   endfunction

endpackage
`default_nettype wire

// File: rtl/micro_sequencer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : micro_sequencer_if
//  Description : Microword fields, datapath status and sequencer outputs.
//                master = controller/ROM side, slave = sequencer.
//                MICRO_SINGLE_STEP_EN adds the step_mode/step inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface micro_sequencer_if #(
   parameter int UADDR_WIDTH = 10
);
   import micro_sequencer_pkg::*;

   logic [2:0]             next_control;
   logic [3:0]             condition_select;
   logic [UADDR_WIDTH-1:0] branch_address;
   logic [15:0]            ir;
   logic                   alu_cout;
   logic                   shifter_cout;
   logic                   lbus_msb;
   logic                   rbus_msb;
   logic                   sbus_msb;
   logic [15:0]            abus;
   logic                   inbus_valid;
   logic [UADDR_WIDTH-1:0] uaddr_next;
   logic [UADDR_WIDTH-1:0] uaddr;
   logic                   mword_valid;
   logic                   hold;
   logic                   halted;
   logic                   fault;

`ifdef MICRO_SINGLE_STEP_EN
   logic                   step_mode;
   logic                   step;

   modport master (
      output next_control, condition_select, branch_address, ir,
             alu_cout, shifter_cout, lbus_msb, rbus_msb, sbus_msb,
             abus, inbus_valid, step_mode, step,
      input  uaddr_next, uaddr, mword_valid, hold, halted, fault
   );

   modport slave (
      input  next_control, condition_select, branch_address, ir,
             alu_cout, shifter_cout, lbus_msb, rbus_msb, sbus_msb,
             abus, inbus_valid, step_mode, step,
      output uaddr_next, uaddr, mword_valid, hold, halted, fault
   );
`else
   modport master (
      output next_control, condition_select, branch_address, ir,
             alu_cout, shifter_cout, lbus_msb, rbus_msb, sbus_msb,
             abus, inbus_valid,
      input  uaddr_next, uaddr, mword_valid, hold, halted, fault
   );

   modport slave (
      input  next_control, condition_select, branch_address, ir,
             alu_cout, shifter_cout, lbus_msb, rbus_msb, sbus_msb,
             abus, inbus_valid,
      output uaddr_next, uaddr, mword_valid, hold, halted, fault
   );
`endif

endinterface
`default_nettype wire

// File: rtl/micro_return_stack.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : micro_return_stack
//  Description : LIFO of return addresses for microsubroutine calls.
//                DEPTH must be a power of two >= 2. push and pop must not
//                be asserted together.
//  Revision    : 1.0 - initial release
// ============================================================================
module micro_return_stack
   import micro_sequencer_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 10
) (
   input  wire logic             clk,
   input  wire logic             reset,
   input  wire logic             push,
   input  wire logic             pop,
   input  wire logic [WIDTH-1:0] push_data,
   output logic      [WIDTH-1:0] top_data,
   output logic                  full,
   output logic                  empty
);

   localparam int                 c_PTR_W   = $clog2(DEPTH);
   localparam logic [c_PTR_W:0]   c_CNT_ONE = (c_PTR_W+1)'(1);
   localparam logic [c_PTR_W:0]   c_CNT_MAX = (c_PTR_W+1)'(DEPTH);
   localparam logic [c_PTR_W-1:0] c_IDX_ONE = c_PTR_W'(1);

   logic [c_PTR_W:0]   r_count;
   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [c_PTR_W-1:0] w_top_idx;

   // Occupancy count doubles as the write pointer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else if (push) begin
         r_count <= r_count + c_CNT_ONE;
      end else if (pop) begin
         r_count <= r_count - c_CNT_ONE;
      end
   end

   // Entry storage needs no reset: the count guards every read.
   always_ff @(posedge clk) begin
      if (push) begin
         r_mem[r_count[c_PTR_W-1:0]] <= push_data;
      end
   end

   assign w_top_idx = r_count[c_PTR_W-1:0] - c_IDX_ONE;
   assign top_data  = r_mem[w_top_idx];
   assign full      = (r_count == c_CNT_MAX);
   assign empty     = (r_count == '0);

`ifndef SYNTHESIS
   a_no_push_and_pop : assert property (@(posedge clk) disable iff (reset) !(push && pop));
`endif

endmodule
`default_nettype wire

// File: rtl/micro_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : micro_sequencer
//  Description : Control-store address generator for the micro-1 controller.
//                Produces uaddr_next for the synchronous ROM and the
//                registered uaddr of the microword now presented; handles
//                conditional branches, call/return and opcode dispatch.
//                Optional macro MICRO_SINGLE_STEP_EN adds single stepping.
//  Revision    : 1.0 - initial release
// ============================================================================
module micro_sequencer
   import micro_sequencer_pkg::*;
#(
   parameter int                     UADDR_WIDTH   = 10,
   parameter int                     STACK_DEPTH   = 4,
   parameter logic [UADDR_WIDTH-1:0] DISPATCH_BASE = 'h100
) (
   input wire logic         clk,
   input wire logic         reset,
   micro_sequencer_if.slave bus
);

   localparam logic [UADDR_WIDTH-1:0] c_UADDR_ONE = UADDR_WIDTH'(1);

   sequencer_state_t       r_state;
   sequencer_state_t       w_state_next;
   logic [UADDR_WIDTH-1:0] r_uaddr;
   logic [UADDR_WIDTH-1:0] w_uaddr_next;
   logic [UADDR_WIDTH-1:0] w_uaddr_inc;
   logic [UADDR_WIDTH-1:0] w_dispatch;
   logic [UADDR_WIDTH-1:0] w_stack_top;
   logic [7:0]             w_status;
   logic                   w_cond;
   logic                   w_step_stall;
   logic                   w_push;
   logic                   w_pop;
   logic                   w_stack_full;
   logic                   w_stack_empty;
   logic                   w_hold;
   logic                   w_valid;
   logic                   w_unused_ir;

   assign w_uaddr_inc = r_uaddr + c_UADDR_ONE;
   assign w_dispatch  = DISPATCH_BASE + UADDR_WIDTH'(bus.ir[15:8]);
   assign w_unused_ir = ^bus.ir[7:0];

   assign w_status = {bus.inbus_valid, (bus.abus == 16'h0000), bus.sbus_msb, bus.rbus_msb,
                      bus.lbus_msb, bus.shifter_cout, bus.alu_cout, 1'b1};
   assign w_cond   = eval_condition(bus.condition_select, w_status);

`ifdef MICRO_SINGLE_STEP_EN
   assign w_step_stall = bus.step_mode & ~bus.step;
`else
   assign w_step_stall = 1'b0;
`endif

   micro_return_stack #(
      .DEPTH (STACK_DEPTH),
      .WIDTH (UADDR_WIDTH)
   ) u_return_stack (
      .clk       (clk),
      .reset     (reset),
      .push      (w_push),
      .pop       (w_pop),
      .push_data (w_uaddr_inc),
      .top_data  (w_stack_top),
      .full      (w_stack_full),
      .empty     (w_stack_empty)
   );

   // State and presented-address registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_BOOT;
         r_uaddr <= '0;
      end else begin
         r_state <= w_state_next;
         r_uaddr <= w_uaddr_next;
      end
   end

   // Next-address selection, stack control and state transitions.
   always_comb begin
      w_state_next = r_state;
      w_uaddr_next = r_uaddr;
      w_hold       = 1'b0;
      w_valid      = 1'b0;
      w_push       = 1'b0;
      w_pop        = 1'b0;
      case (r_state)
         ST_BOOT: begin
            // One cycle for the ROM to deliver the word at address 0.
            w_uaddr_next = '0;
            w_state_next = ST_RUN;
         end
         ST_RUN: begin
            w_valid = 1'b1;
            if (w_step_stall) begin
               w_hold = 1'b1;
            end else begin
               case (next_control_t'(bus.next_control))
                  NC_NEXT:     w_uaddr_next = w_uaddr_inc;
                  NC_JUMP:     w_uaddr_next = bus.branch_address;
                  NC_CJUMP:    w_uaddr_next = w_cond ? bus.branch_address : w_uaddr_inc;
                  NC_CALL: begin
                     if (w_stack_full) begin
                        w_state_next = ST_FAULT;
                     end else begin
                        w_push       = 1'b1;
                        w_uaddr_next = bus.branch_address;
                     end
                  end
                  NC_RET: begin
                     if (w_stack_empty) begin
                        w_state_next = ST_FAULT;
                     end else begin
                        w_pop        = 1'b1;
                        w_uaddr_next = w_stack_top;
                     end
                  end
                  NC_DISPATCH: w_uaddr_next = w_dispatch;
                  NC_WAIT: begin
                     if (bus.inbus_valid) begin
                        w_uaddr_next = w_uaddr_inc;
                     end else begin
                        w_hold = 1'b1;
                     end
                  end
                  NC_HALT:     w_state_next = ST_HALTED;
                  default:     w_uaddr_next = r_uaddr;
               endcase
            end
         end
         ST_HALTED: w_hold = 1'b1;
         ST_FAULT:  w_hold = 1'b1;
         default:   w_state_next = ST_BOOT;
      endcase
   end

   assign bus.uaddr_next  = w_uaddr_next;
   assign bus.uaddr       = r_uaddr;
   assign bus.mword_valid = w_valid;
   assign bus.hold        = w_hold;
   assign bus.halted      = (r_state == ST_HALTED);
   assign bus.fault       = (r_state == ST_FAULT);

endmodule
`default_nettype wire
